// File: rtl/trackball_quad_gen.sv
// trackball_quad_gen: turns MiSTer PS/2 mouse packets into the paced direction/clock
// pairs expected by the Centipede trackball input. Motion is accumulated per axis
// and replayed one step per tick; each step flips the axis clock and sets its direction.
// Optional feature: define TRAK_JOY_EMU_EN to let the joystick feed the accumulators.
module trackball_quad_gen #(
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 1,
    parameter int ACC_LIM  = 1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        flip,
    input  logic [3:0]  joy,
    output logic [3:0]  trak_o,
    output logic [7:0]  trakball_o,
    output logic        busy_o
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic signed [SUM_W-1:0] LIM_P    = SUM_W'(ACC_LIM);
    localparam logic signed [SUM_W-1:0] LIM_N    = -LIM_P;

    // state
    logic                    old_toggle_q;
    logic                    arm_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_x_q;
    logic signed [ACC_W-1:0] acc_y_q;
    logic                    x_dir_q;
    logic                    x_clk_q;
    logic                    y_dir_q;
    logic                    y_clk_q;
    logic                    busy_q;

    // next state
    logic [CNT_W-1:0]        cnt_d;
    logic signed [ACC_W-1:0] acc_x_d;
    logic signed [ACC_W-1:0] acc_y_d;
    logic                    x_dir_d;
    logic                    x_clk_d;
    logic                    y_dir_d;
    logic                    y_clk_d;
    logic                    busy_d;

    // per-cycle decode
    logic                    tick_c;
    logic                    pkt_c;
    logic                    x_step_c;
    logic                    y_step_c;
    logic [8:0]              raw_x_c;
    logic [8:0]              raw_y_c;
    logic signed [ACC_W-1:0] dx_ext_c;
    logic signed [ACC_W-1:0] dy_ext_c;
    logic signed [ACC_W-1:0] dx_c;
    logic signed [ACC_W-1:0] dy_c;
    logic signed [ACC_W-1:0] jx_c;
    logic signed [ACC_W-1:0] jy_c;
    logic                    unused_bits_c;

    // One accumulator update: step toward zero, add packet and joystick motion, saturate.
    function automatic logic signed [ACC_W-1:0] axis_next(
        input logic signed [ACC_W-1:0] acc,
        input logic                    step_en,
        input logic                    add_pkt,
        input logic signed [ACC_W-1:0] delta,
        input logic signed [ACC_W-1:0] joy_d
    );
        logic signed [SUM_W-1:0] step;
        logic signed [SUM_W-1:0] pkt_add;
        logic signed [SUM_W-1:0] sum;
        step    = '0;
        pkt_add = '0;
        if (step_en) begin
            // a step always moves the count one unit back toward zero
            step = acc[ACC_W-1] ? SUM_W'(1) : '1;
        end
        if (add_pkt) begin
            pkt_add = SUM_W'(delta);
        end
        sum = SUM_W'(acc) + step + pkt_add + SUM_W'(joy_d);
        if (sum > LIM_P) begin
            sum = LIM_P;
        end else if (sum < LIM_N) begin
            sum = LIM_N;
        end
        return ACC_W'(sum);
    endfunction

    // Packet strobe, step tick and signed deltas for this cycle.
    always_comb begin
        tick_c   = (cnt_q == CNT_LAST);
        pkt_c    = arm_q && (ps2_mouse[24] != old_toggle_q);
        raw_x_c  = {ps2_mouse[4], ps2_mouse[15:8]};
        raw_y_c  = {ps2_mouse[5], ps2_mouse[23:16]};
        // negate after widening so a flipped -256 becomes +256 instead of wrapping
        dx_ext_c = ACC_W'($signed(raw_x_c));
        dy_ext_c = ACC_W'($signed(raw_y_c));
        dx_c     = flip ? -dx_ext_c : dx_ext_c;
        dy_c     = flip ? -dy_ext_c : dy_ext_c;
        x_step_c = tick_c && (acc_x_q != '0);
        y_step_c = tick_c && (acc_y_q != '0);
    end

`ifdef TRAK_JOY_EMU_EN
    // Joystick adds one unit per axis per tick; opposing directions cancel, flip mirrors.
    always_comb begin
        jx_c = '0;
        jy_c = '0;
        if (tick_c) begin
            case ({joy[1], joy[0]})
                2'b01:   jx_c = ACC_W'(1);
                2'b10:   jx_c = '1;
                default: jx_c = '0;
            endcase
            case ({joy[2], joy[3]})
                2'b01:   jy_c = ACC_W'(1);
                2'b10:   jy_c = '1;
                default: jy_c = '0;
            endcase
            if (flip) begin
                jx_c = -jx_c;
                jy_c = -jy_c;
            end
        end
    end

    assign unused_bits_c = ^{ps2_mouse[7:6], ps2_mouse[3:0]};
`else
    // Mouse-only build: joystick contributes nothing.
    always_comb begin
        jx_c = '0;
        jy_c = '0;
    end

    assign unused_bits_c = ^{ps2_mouse[7:6], ps2_mouse[3:0], joy};
`endif

    // Next-state logic for the tick counter, accumulators and step outputs.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        x_dir_d = x_dir_q;
        x_clk_d = x_clk_q;
        y_dir_d = y_dir_q;
        y_clk_d = y_clk_q;
        busy_d  = busy_q;

        if (tick_c) begin
            cnt_d = '0;
        end

        if (x_step_c) begin
            x_dir_d = ~acc_x_q[ACC_W-1];
            x_clk_d = ~x_clk_q;
        end
        if (y_step_c) begin
            y_dir_d = ~acc_y_q[ACC_W-1];
            y_clk_d = ~y_clk_q;
        end

        acc_x_d = axis_next(acc_x_q, x_step_c, pkt_c, dx_c, jx_c);
        acc_y_d = axis_next(acc_y_q, y_step_c, pkt_c, dy_c, jy_c);
        busy_d  = (acc_x_d != '0) || (acc_y_d != '0);
    end

    // State register; the toggle tracker arms one cycle after reset release.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_toggle_q <= 1'b0;
            arm_q        <= 1'b0;
            cnt_q        <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            x_dir_q      <= 1'b0;
            x_clk_q      <= 1'b0;
            y_dir_q      <= 1'b0;
            y_clk_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            old_toggle_q <= ps2_mouse[24];
            arm_q        <= 1'b1;
            cnt_q        <= cnt_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            x_dir_q      <= x_dir_d;
            x_clk_q      <= x_clk_d;
            y_dir_q      <= y_dir_d;
            y_clk_q      <= y_clk_d;
            busy_q       <= busy_d;
        end
    end

    // Outputs are the registers themselves; trakball_o duplicates each bit.
    assign trak_o     = {x_dir_q, x_clk_q, y_dir_q, y_clk_q};
    assign trakball_o = {x_dir_q, x_dir_q, x_clk_q, x_clk_q, y_dir_q, y_dir_q, y_clk_q, y_clk_q};
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Bench for trackball_quad_gen: three instances (STEP_DIV 1, 4, 2) share stimulus and
// are compared each cycle against an integer model of the accumulate/step rules.
`timescale 1ns/1ps
module tb_trackball_quad_gen;

    localparam int N_DUT = 3;
    localparam int LIM   = 1023;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [24:0] ps2_mouse;
    logic        flip;
    logic [3:0]  joy;
    logic [3:0]  trak     [N_DUT];
    logic [7:0]  trakball [N_DUT];
    logic        busy     [N_DUT];

    int n_chk  = 0;
    int n_fail = 0;
    bit tgl;

    // model state
    int m_ax  [N_DUT];
    int m_ay  [N_DUT];
    int m_cnt [N_DUT];
    bit m_xd  [N_DUT];
    bit m_xc  [N_DUT];
    bit m_yd  [N_DUT];
    bit m_yc  [N_DUT];
    bit m_busy[N_DUT];
    bit m_old;
    bit m_arm;

    always #5 clk_sys = ~clk_sys;

    trackball_quad_gen #(.ACC_W(12), .STEP_DIV(1), .ACC_LIM(LIM)) u_dut_d1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .flip(flip), .joy(joy),
        .trak_o(trak[0]), .trakball_o(trakball[0]), .busy_o(busy[0]));
    trackball_quad_gen #(.ACC_W(12), .STEP_DIV(4), .ACC_LIM(LIM)) u_dut_d4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .flip(flip), .joy(joy),
        .trak_o(trak[1]), .trakball_o(trakball[1]), .busy_o(busy[1]));
    trackball_quad_gen #(.ACC_W(12), .STEP_DIV(2), .ACC_LIM(LIM)) u_dut_d2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .flip(flip), .joy(joy),
        .trak_o(trak[2]), .trakball_o(trakball[2]), .busy_o(busy[2]));

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 2);
    endfunction

    function automatic int clamp_lim(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            m_ax[i] = 0; m_ay[i] = 0; m_cnt[i] = 0;
            m_xd[i] = 0; m_xc[i] = 0; m_yd[i] = 0; m_yc[i] = 0; m_busy[i] = 0;
        end
        m_old = 0;
        m_arm = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int dx, dy, jx, jy, nx, ny;
        bit pkt, tk;
        if (!reset_n) begin
            model_reset();
        end else begin
            pkt = m_arm && (ps2_mouse[24] != m_old);
            dx = int'(ps2_mouse[15:8]) - (ps2_mouse[4] ? 256 : 0);
            dy = int'(ps2_mouse[23:16]) - (ps2_mouse[5] ? 256 : 0);
            jx = 0;
            jy = 0;
`ifdef TRAK_JOY_EMU_EN
            jx = int'(joy[0]) - int'(joy[1]);
            jy = int'(joy[3]) - int'(joy[2]);
`endif
            if (flip) begin
                dx = -dx; dy = -dy; jx = -jx; jy = -jy;
            end
            for (int i = 0; i < N_DUT; i++) begin
                tk = (m_cnt[i] == div_of(i) - 1);
                nx = m_ax[i];
                ny = m_ay[i];
                if (tk && nx != 0) begin
                    m_xd[i] = (nx > 0);
                    m_xc[i] = !m_xc[i];
                    nx += (nx > 0) ? -1 : 1;
                end
                if (tk && ny != 0) begin
                    m_yd[i] = (ny > 0);
                    m_yc[i] = !m_yc[i];
                    ny += (ny > 0) ? -1 : 1;
                end
                if (pkt) begin nx += dx; ny += dy; end
                if (tk)  begin nx += jx; ny += jy; end
                m_ax[i]   = clamp_lim(nx);
                m_ay[i]   = clamp_lim(ny);
                m_cnt[i]  = tk ? 0 : m_cnt[i] + 1;
                m_busy[i] = (m_ax[i] != 0) || (m_ay[i] != 0);
            end
            m_old = ps2_mouse[24];
            m_arm = 1;
        end
    endtask

    task automatic step_cycle();
        model_clock();
        @(posedge clk_sys);
        #1;
    endtask

    // Present a new packet (toggle flips); junk goes into the unused bits.
    task automatic send_pkt(input bit xs, input logic [7:0] xm, input bit ys, input logic [7:0] ym);
        logic [5:0] junk;
        junk = 6'($urandom);
        tgl = !tgl;
        ps2_mouse = {tgl, ym, xm, junk[5:4], ys, xs, junk[3:0]};
    endtask

    function automatic logic [38:0] exp_vec();
        logic [38:0] v;
        for (int i = 0; i < N_DUT; i++)
            v[i*13 +: 13] = {m_xd[i], m_xd[i], m_xc[i], m_xc[i], m_yd[i], m_yd[i], m_yc[i], m_yc[i],
                             m_xd[i], m_xc[i], m_yd[i], m_yc[i], m_busy[i]};
        return v;
    endfunction

    function automatic logic [38:0] act_vec();
        logic [38:0] v;
        for (int i = 0; i < N_DUT; i++) v[i*13 +: 13] = {trakball[i], trak[i], busy[i]};
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 0;
        tgl = 1;
        ps2_mouse = {1'b1, 24'($urandom)};
        step_cycle();
        step_cycle();
        n_chk++;
        if (act_vec() !== 39'd0) begin
            n_fail++; $display("FAIL reset_hold: got %h want 0", act_vec());
        end
        reset_n = 1;
        for (int c = 0; c < 100; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if ({trak[0], busy[0]} !== 5'd0) begin
            n_fail++; $display("FAIL reset_quiet: got %b want 00000", {trak[0], busy[0]});
        end
    endtask

    task automatic test_x_plus5();
        int tog1, tog4, first, last;
        logic p1, p4;
        logic [1:0] y_before;
        tog1 = 0; tog4 = 0; first = -1; last = -1;
        p1 = trak[0][2]; p4 = trak[1][2];
        y_before = trak[0][1:0];
        send_pkt(0, 8'h05, 0, 8'h00);
        for (int c = 0; c < 30; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL x_plus5 cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[0][2] !== p1) begin
                tog1++; if (first < 0) first = c; last = c;
            end
            if (trak[1][2] !== p4) tog4++;
            p1 = trak[0][2]; p4 = trak[1][2];
        end
        n_chk++;
        if (tog1 != 5 || tog4 != 5) begin
            n_fail++; $display("FAIL x_plus5_count: got %0d/%0d want 5/5", tog1, tog4);
        end
        n_chk++;
        if (last - first != 4) begin
            n_fail++; $display("FAIL x_plus5_consecutive: span %0d want 4", last - first);
        end
        n_chk++;
        if ({trak[0][3], busy[0], trak[0][1:0]} !== {1'b1, 1'b0, y_before}) begin
            n_fail++; $display("FAIL x_plus5_state: got %b want %b", {trak[0][3], busy[0], trak[0][1:0]},
                               {1'b1, 1'b0, y_before});
        end
    endtask

    task automatic test_y_minus3();
        int tog, prev_c, bad;
        logic p;
        tog = 0; prev_c = -1; bad = 0;
        p = trak[1][0];
        send_pkt(0, 8'h00, 1, 8'hFD);
        for (int c = 0; c < 30; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL y_minus3 cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            n_chk++;
            if (trakball[1][1:0] !== {trak[1][0], trak[1][0]}) begin
                n_fail++; $display("FAIL y_mirror cyc %0d: got %b want %b", c, trakball[1][1:0], {2{trak[1][0]}});
            end
            if (trak[1][0] !== p) begin
                tog++;
                if (prev_c >= 0 && c - prev_c != 4) bad++;
                prev_c = c;
            end
            p = trak[1][0];
        end
        n_chk++;
        if (tog != 3 || bad != 0 || trak[1][1] !== 1'b0) begin
            n_fail++; $display("FAIL y_minus3_steps: toggles %0d badgap %0d dir %b want 3 0 0", tog, bad, trak[1][1]);
        end
    endtask

    task automatic test_flip();
        int tog;
        logic p;
        tog = 0;
        flip = 1;
        p = trak[0][2];
        send_pkt(0, 8'h02, 0, 8'h00);
        for (int c = 0; c < 20; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL flip cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[0][2] !== p) tog++;
            p = trak[0][2];
        end
        n_chk++;
        if (tog != 2 || trak[0][3] !== 1'b0) begin
            n_fail++; $display("FAIL flip_steps: toggles %0d dir %b want 2 0", tog, trak[0][3]);
        end
        flip = 0;
    endtask

    task automatic test_boundaries();
        int tog1, tog4;
        logic [3:0] t_before;
        logic p1, p4;
        // zero-delta packet leaves everything alone
        t_before = trak[0];
        send_pkt(0, 8'h00, 0, 8'h00);
        for (int c = 0; c < 10; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL zero_pkt cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if ({trak[0], busy[0]} !== {t_before, 1'b0}) begin
            n_fail++; $display("FAIL zero_pkt_state: got %b want %b", {trak[0], busy[0]}, {t_before, 1'b0});
        end
        // most negative delta: -256
        tog1 = 0; tog4 = 0;
        p1 = trak[0][2]; p4 = trak[1][2];
        send_pkt(1, 8'h00, 0, 8'h00);
        for (int c = 0; c < 1100; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL minus256 cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[0][2] !== p1) tog1++;
            if (trak[1][2] !== p4) tog4++;
            p1 = trak[0][2]; p4 = trak[1][2];
        end
        n_chk++;
        if (tog1 != 256 || tog4 != 256 || trak[0][3] !== 1'b0) begin
            n_fail++; $display("FAIL minus256_steps: got %0d/%0d dir %b want 256/256 0", tog1, tog4, trak[0][3]);
        end
    endtask

    task automatic test_saturate();
        int tog1, tog4;
        logic p1, p4;
        for (int k = 0; k < 8; k++) begin
            send_pkt(0, 8'hFF, 0, 8'h00);
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL sat_burst pkt %0d: got %h want %h", k, act_vec(), exp_vec());
            end
        end
        tog1 = 0; tog4 = 0;
        p1 = trak[0][2]; p4 = trak[1][2];
        for (int c = 0; c < 4200; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL sat_drain cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[0][2] !== p1) tog1++;
            if (trak[1][2] !== p4) tog4++;
            p1 = trak[0][2]; p4 = trak[1][2];
        end
        n_chk++;
        if (tog1 != LIM || tog4 != LIM) begin
            n_fail++; $display("FAIL sat_count: got %0d/%0d want %0d", tog1, tog4, LIM);
        end
    endtask

    task automatic test_reset_mid();
        int tog;
        logic p;
        logic [2:0] pa;
        tog = 0;
        p = trak[0][2];
        send_pkt(0, 8'd10, 0, 8'h00);
        for (int c = 0; c < 20 && tog < 4; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL mid_run cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[0][2] !== p) tog++;
            p = trak[0][2];
        end
        n_chk++;
        if (tog != 4) begin
            n_fail++; $display("FAIL mid_reach4: got %0d toggles want 4", tog);
        end
        #2;
        reset_n = 0;
        #1;
        model_reset();
        n_chk++;
        if (act_vec() !== 39'd0) begin
            n_fail++; $display("FAIL mid_async_clear: got %h want 0", act_vec());
        end
        for (int c = 0; c < 3; c++) step_cycle();
        reset_n = 1;
        tog = 0;
        for (int i = 0; i < N_DUT; i++) pa[i] = trak[i][2];
        for (int c = 0; c < 40; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL mid_after cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            for (int i = 0; i < N_DUT; i++) begin
                if (trak[i][2] !== pa[i]) tog++;
                pa[i] = trak[i][2];
            end
        end
        n_chk++;
        if (tog != 0) begin
            n_fail++; $display("FAIL mid_no_more_steps: got %0d toggles want 0", tog);
        end
    endtask

    task automatic test_joy();
        int tog, prev_c, bad;
        logic p;
        tog = 0; prev_c = -1; bad = 0;
        p = trak[2][2];
        joy = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL joy_hold cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[2][2] !== p) begin
                tog++;
                if (prev_c >= 0 && c - prev_c != 2) bad++;
                prev_c = c;
            end
            p = trak[2][2];
        end
`ifdef TRAK_JOY_EMU_EN
        n_chk++;
        if (tog < 18 || bad != 0 || trak[2][3] !== 1'b1) begin
            n_fail++; $display("FAIL joy_held: toggles %0d badgap %0d dir %b want >=18 0 1", tog, bad, trak[2][3]);
        end
`else
        n_chk++;
        if (tog != 0 || busy[2] !== 1'b0) begin
            n_fail++; $display("FAIL joy_ignored: toggles %0d busy %b want 0 0", tog, busy[2]);
        end
`endif
        joy = 4'b0000;
        tog = 0;
        for (int c = 0; c < 20; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL joy_release cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (trak[2][2] !== p) tog++;
            p = trak[2][2];
        end
`ifdef TRAK_JOY_EMU_EN
        n_chk++;
        if (tog != 1) begin
            n_fail++; $display("FAIL joy_stop: got %0d toggles after release want 1", tog);
        end
`endif
    endtask

    task automatic test_random();
        bit xs, ys;
        logic [7:0] xm, ym;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) flip = !flip;
            if ((c % 8) == 0) joy = 4'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                xs = 1'($urandom); ys = 1'($urandom);
                xm = 8'($urandom); ym = 8'($urandom);
                if (flip && xs && xm == 8'h00) xm = 8'h01;
                if (flip && ys && ym == 8'h00) ym = 8'h01;
                send_pkt(xs, xm, ys, ym);
            end
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        joy = 4'b0000;
        flip = 0;
        for (int c = 0; c < 4200; c++) begin
            step_cycle();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_drain cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if ({busy[0], busy[1], busy[2]} !== 3'b000) begin
            n_fail++; $display("FAIL random_idle: busy %b want 000", {busy[0], busy[1], busy[2]});
        end
    endtask

    initial begin
        reset_n   = 0;
        ps2_mouse = '0;
        flip      = 0;
        joy       = '0;
        tgl       = 0;
        model_reset();
        test_reset();
        test_x_plus5();
        test_y_minus3();
        test_flip();
        test_boundaries();
        test_saturate();
        test_reset_mid();
        test_joy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
